// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution frame sequencer: phase codes,
// FSM state encoding and the fixed block/settle counts.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    PH_LOAD = 2'b00,
    PH_PROC = 2'b01,
    PH_OUT  = 2'b10,
    PH_IDLE = 2'b11
  } phase_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    L_SET  = 4'd1,
    L_REQ  = 4'd2,
    L_PUL  = 4'd3,
    P_SET  = 4'd4,
    P_WAIT = 4'd5,
    P_PUL  = 4'd6,
    O_SET  = 4'd7,
    O_REQ  = 4'd8,
    O_PUL  = 4'd9,
    DONE   = 4'd10
  } state_t;

  localparam int SET_CYCLES = 2;
  localparam int OUT_BLKS   = 2;
  localparam int STEP_BLKS  = 2;

  function automatic phase_t state_phase(input state_t s);
    phase_t p;
    case (s)
      L_SET, L_REQ, L_PUL:  p = PH_LOAD;
      P_SET, P_WAIT, P_PUL: p = PH_PROC;
      O_SET, O_REQ, O_PUL:  p = PH_OUT;
      default:              p = PH_IDLE;
    endcase
    return p;
  endfunction

  function automatic logic is_set_state(input state_t s);
    return (s == L_SET) || (s == P_SET) || (s == O_SET);
  endfunction

  function automatic logic is_pul_state(input state_t s);
    return (s == L_PUL) || (s == P_PUL) || (s == O_PUL);
  endfunction

endpackage

// File: rtl/chblk_strobe.sv
// Settle timer for the *_SET states and the change-block strobe generator;
// the strobe is suppressed if a pulse state were ever entered back to back.
module chblk_strobe
  import conv_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_set,
  input  logic in_pul,
  output logic settled,
  output logic chblk
);

  localparam int SW = $clog2(SET_CYCLES + 1);

  logic [SW-1:0] settle_cnt_reg;
  logic          strobe_q_reg;

  // settled rises on the last SET cycle so the FSM leaves after exactly SET_CYCLES
  assign settled = in_set && (settle_cnt_reg == SW'(SET_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt_reg <= '0;
    end else if (in_set && !settled) begin
      settle_cnt_reg <= settle_cnt_reg + 1'b1;
    end else begin
      settle_cnt_reg <= '0;
    end
  end

  assign chblk = in_pul && !strobe_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q_reg <= 1'b0;
    end else begin
      strobe_q_reg <= chblk;
    end
  end

endmodule

// File: rtl/conv_seq.sv
// Convolution frame sequencer: LOAD/PROC/OUT iterations with change-block strobes.
// Optional i_abort input when CONV_SEQ_ABORT_EN is defined.
module conv_seq
  import conv_seq_pkg::*;
#(
  parameter int N   = 16,
  parameter int ITW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [ITW-1:0] i_niter,
  input  logic           i_blk_ack,
  input  logic           i_proc_done,
`ifdef CONV_SEQ_ABORT_EN
  input  logic           i_abort,
`endif
  output logic           o_sop,
  output logic           o_eop,
  output logic           o_chblk,
  output logic           o_blk_req,
  output logic           o_busy,
  output logic           o_done
);

  localparam int BW = $clog2(N + 1);
  localparam logic [BW-1:0] LOAD_FIRST_LAST = BW'(N - 1);
  localparam logic [BW-1:0] LOAD_STEP_LAST  = BW'(STEP_BLKS - 1);
  localparam logic [BW-1:0] OUT_LAST        = BW'(OUT_BLKS - 1);

  state_t         state_reg, state_next;
  logic [BW-1:0]  blk_cnt_reg, blk_cnt_next;
  logic [ITW-1:0] iter_cnt_reg, iter_cnt_next;
  logic           first_iter_reg, first_iter_next;

  logic   in_set;
  logic   in_pul;
  logic   settled;
  logic   load_last;
  phase_t phase;

  chblk_strobe u_strobe (
    .clk     (clk),
    .rst     (rst),
    .in_set  (in_set),
    .in_pul  (in_pul),
    .settled (settled),
    .chblk   (o_chblk)
  );

  assign in_set = is_set_state(state_reg);
  assign in_pul = is_pul_state(state_reg);

  // the first iteration fills the whole kernel window; later ones only slide it
  assign load_last = first_iter_reg ? (blk_cnt_reg == LOAD_FIRST_LAST)
                                    : (blk_cnt_reg == LOAD_STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      blk_cnt_reg    <= '0;
      iter_cnt_reg   <= '0;
      first_iter_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      blk_cnt_reg    <= blk_cnt_next;
      iter_cnt_reg   <= iter_cnt_next;
      first_iter_reg <= first_iter_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    blk_cnt_next    = blk_cnt_reg;
    iter_cnt_next   = iter_cnt_reg;
    first_iter_next = first_iter_reg;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (i_niter != '0) begin
            state_next      = L_SET;
            iter_cnt_next   = i_niter;
            blk_cnt_next    = '0;
            first_iter_next = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      L_SET: if (settled) state_next = L_REQ;
      L_REQ: if (i_blk_ack) state_next = L_PUL;
      L_PUL: begin
        if (load_last) begin
          state_next      = P_SET;
          blk_cnt_next    = '0;
          first_iter_next = 1'b0;
        end else begin
          state_next   = L_REQ;
          blk_cnt_next = blk_cnt_reg + 1'b1;
        end
      end
      P_SET:  if (settled) state_next = P_WAIT;
      P_WAIT: if (i_proc_done) state_next = P_PUL;
      P_PUL:  state_next = O_SET;
      O_SET:  if (settled) state_next = O_REQ;
      O_REQ:  if (i_blk_ack) state_next = O_PUL;
      O_PUL: begin
        if (blk_cnt_reg == OUT_LAST) begin
          blk_cnt_next  = '0;
          iter_cnt_next = iter_cnt_reg - 1'b1;
          state_next    = (iter_cnt_reg == ITW'(1)) ? DONE : L_SET;
        end else begin
          state_next   = O_REQ;
          blk_cnt_next = blk_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next      = IDLE;
        blk_cnt_next    = '0;
        iter_cnt_next   = '0;
        first_iter_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase

`ifdef CONV_SEQ_ABORT_EN
    // DONE is excluded so an abort held high cannot stretch the done pulse
    if (i_abort && (state_reg != IDLE) && (state_reg != DONE)) begin
      state_next      = DONE;
      blk_cnt_next    = '0;
      iter_cnt_next   = '0;
      first_iter_next = 1'b0;
    end
`endif
  end

  assign phase     = state_phase(state_reg);
  assign o_sop     = phase[0];
  assign o_eop     = phase[1];
  assign o_blk_req = (state_reg == L_REQ) || (state_reg == O_REQ);
  assign o_busy    = (state_reg != IDLE);
  assign o_done    = (state_reg == DONE);

endmodule

// File: tb/tb_conv_seq.sv
// Self-checking bench for conv_seq: rule-level reference model compared every
// cycle, plus directed scenarios for strobe order, stalls, zero-iteration and reset.
module tb_conv_seq;

  localparam int TN   = 4;
  localparam int TITW = 16;

  logic            clk;
  logic            rst = 1'b1;
  logic            i_start = 1'b0;
  logic [TITW-1:0] i_niter = '0;
  logic            i_blk_ack;
  logic            i_proc_done;
  logic            i_abort = 1'b0;
  logic            o_sop, o_eop, o_chblk, o_blk_req, o_busy, o_done;

  conv_seq #(.N(TN), .ITW(TITW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_niter     (i_niter),
    .i_blk_ack   (i_blk_ack),
    .i_proc_done (i_proc_done),
`ifdef CONV_SEQ_ABORT_EN
    .i_abort     (i_abort),
`endif
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_chblk     (o_chblk),
    .o_blk_req   (o_blk_req),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: phase, age in phase, strobes left in phase, iteration index.
  typedef struct packed {
    logic        active;
    logic        done;
    logic [1:0]  phase;
    logic        strobe;
    logic [31:0] age;
    logic [31:0] left;
    logic [31:0] iter;
    logic [31:0] niter;
  } mst_t;

  localparam mst_t M_RST = '{active: 1'b0, done: 1'b0, phase: 2'b11, strobe: 1'b0,
                             age: 32'd0, left: 32'd0, iter: 32'd0, niter: 32'd0};

  function automatic mst_t step(input mst_t m, input logic st, input logic [31:0] nit,
                                input logic ack, input logic pd, input logic ab);
    mst_t n = m;
    n.strobe = 1'b0;
    n.done   = 1'b0;
    if (m.done) begin
      n.active = 1'b0;
      n.phase  = 2'b11;
    end else if (!m.active) begin
      if (st) begin
        if (nit == 0) n.done = 1'b1;
        else begin
          n.active = 1'b1; n.phase = 2'b00; n.age = 0;
          n.left = TN; n.iter = 0; n.niter = nit;
        end
      end
    end else if (ab) begin
      n.active = 1'b0; n.done = 1'b1; n.phase = 2'b11;
    end else if (m.strobe) begin
      if (m.left > 1) begin
        n.left = m.left - 1;
        n.age  = m.age + 1;
      end else begin
        n.age = 0;
        case (m.phase)
          2'b00:   begin n.phase = 2'b01; n.left = 1; end
          2'b01:   begin n.phase = 2'b10; n.left = 2; end
          default: begin
            n.iter = m.iter + 1;
            if (m.iter + 1 == m.niter) begin
              n.active = 1'b0; n.done = 1'b1; n.phase = 2'b11;
            end else begin
              n.phase = 2'b00; n.left = 2;
            end
          end
        endcase
      end
    end else begin
      n.age = m.age + 1;
      if (m.age >= 2 && ((m.phase != 2'b01 && ack) || (m.phase == 2'b01 && pd)))
        n.strobe = 1'b1;
    end
    return n;
  endfunction

  mst_t m;

  always @(posedge clk or posedge rst) begin
    if (rst) m <= M_RST;
    else     m <= step(m, i_start, 32'(i_niter), i_blk_ack, i_proc_done, i_abort);
  end

  // Responder: 0 random, 1 always ready, 2 withheld, 3 ack only
  int mode = 1;
  initial begin
    i_blk_ack   = 1'b0;
    i_proc_done = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       begin i_blk_ack = ($urandom_range(0, 2) == 0); i_proc_done = ($urandom_range(0, 2) == 0); end
        1:       begin i_blk_ack = 1'b1; i_proc_done = 1'b1; end
        3:       begin i_blk_ack = 1'b1; i_proc_done = 1'b0; end
        default: begin i_blk_ack = 1'b0; i_proc_done = 1'b0; end
      endcase
    end
  end

  // Per-cycle compare and timing monitor
  logic [1:0] strobe_log[$];
  int         done_cnt = 0;
  logic [1:0] prev_phase = 2'b11;
  logic       prev_chblk = 1'b0;
  int         ph_age = 0;

  initial begin
    forever begin
      logic [1:0] ph;
      logic [5:0] got6, exp6;
      logic       req_exp;
      @(negedge clk);
      if (rst) begin
        prev_phase = 2'b11; prev_chblk = 1'b0; ph_age = 0;
        continue;
      end
      ph      = {o_eop, o_sop};
      req_exp = m.active && (m.phase != 2'b01) && (m.age >= 2) && !m.strobe;
      got6    = {ph, o_chblk, o_blk_req, o_busy, o_done};
      exp6    = {m.phase, m.strobe, req_exp, m.active || m.done, m.done};
      check("outputs_vs_model", 32'(got6), 32'(exp6));
      if (ph != prev_phase) ph_age = 0;
      else ph_age++;
      if (o_chblk && !prev_chblk) begin
        check("strobe_setup_ge3", 32'(ph_age >= 3), 32'd1);
        strobe_log.push_back(ph);
      end
      if (o_chblk) check("phase_hold_in_strobe", 32'(ph), 32'(prev_phase));
      if (o_done) done_cnt++;
      prev_phase = ph;
      prev_chblk = o_chblk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_frame(input logic [TITW-1:0] n);
    @(negedge clk);
    i_niter = n;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit noise);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (o_done) ok = 1'b1;
      else begin
        if (noise) begin
          i_start = o_busy && ($urandom_range(0, 5) == 0);
          i_niter = TITW'($urandom);
        end
        @(negedge clk);
      end
    end
    i_start = 1'b0;
    check("done_within_budget", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!o_busy) ok = 1'b1;
    end
    check("idle_within_budget", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [1:0] exp_seq[12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10,
                                2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
    int d0, s0, nit, nproc;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({o_eop, o_sop, o_chblk, o_blk_req, o_busy, o_done}), 32'b110000);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    // Strobe ordering, N=4, two iterations
    mode = 1;
    strobe_log.delete();
    d0 = done_cnt;
    start_frame(2);
    run_until_done(300, 1'b0);
    repeat (2) @(negedge clk);
    check("order_count", 32'(strobe_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < strobe_log.size(); i++)
      check("order_phase", 32'(strobe_log[i]), 32'(exp_seq[i]));
    check("order_done_pulses", 32'(done_cnt - d0), 32'd1);
    $display("frame directed niter=2 strobes=%0d", strobe_log.size());

    // Zero-iteration frame
    strobe_log.delete();
    start_frame(0);
    check("zero_iter_done", 32'({o_eop, o_sop, o_chblk, o_done}), 32'b1101);
    @(negedge clk);
    check("zero_iter_after", 32'({o_eop, o_sop, o_busy, o_done}), 32'b1100);
    check("zero_iter_strobes", 32'(strobe_log.size()), 32'd0);
    $display("frame directed niter=0 strobes=%0d", strobe_log.size());

    // Ack withheld for 50 cycles in L_REQ
    mode = 2;
    strobe_log.delete();
    start_frame(1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      check("stall_hold", 32'({o_eop, o_sop, o_chblk, o_blk_req}), 32'b0001);
      @(negedge clk);
    end
    check("stall_no_strobe", 32'(strobe_log.size()), 32'd0);
    mode = 1;
    run_until_done(300, 1'b0);
    wait_idle();
    $display("frame directed stall niter=1 strobes=%0d", strobe_log.size());

    // Reset in O_REQ of iteration 1
    begin
      bit ok = 1'b0;
      strobe_log.delete();
      start_frame(3);
      for (int i = 0; i < 300 && strobe_log.size() < 10; i++) @(negedge clk);
      mode = 2;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if ({o_eop, o_sop} == 2'b10 && o_blk_req) ok = 1'b1;
      end
      check("reached_out_req_iter1", 32'(ok), 32'd1);
      d0 = done_cnt;
      s0 = strobe_log.size();
      @(posedge clk); #2 rst = 1'b1;
      #1 check("reset_midframe", 32'({o_eop, o_sop, o_chblk, o_busy, o_done}), 32'b11000);
      @(posedge clk); #2 rst = 1'b0;
      mode = 1;
      repeat (20) @(negedge clk);
      check("reset_no_strobe", 32'(strobe_log.size() - s0), 32'd0);
      check("reset_no_done", 32'(done_cnt - d0), 32'd0);
      check("reset_stays_idle", 32'(o_busy), 32'd0);
      $display("frame directed reset-abandon strobes=%0d", strobe_log.size());
    end

`ifdef CONV_SEQ_ABORT_EN
    begin
      bit ok = 1'b0;
      mode = 3;
      strobe_log.delete();
      start_frame(1);
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if ({o_eop, o_sop} == 2'b01) ok = 1'b1;
      end
      check("reached_proc", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check("abort_done", 32'({o_eop, o_sop, o_chblk, o_done}), 32'b1101);
      @(negedge clk);
      check("abort_idle", 32'({o_eop, o_sop, o_busy, o_done}), 32'b1100);
      nproc = 0;
      foreach (strobe_log[i]) if (strobe_log[i] == 2'b01) nproc++;
      check("abort_no_proc_strobe", 32'(nproc), 32'd0);
      $display("frame directed abort strobes=%0d", strobe_log.size());
    end
`endif

    // Randomized frames
    mode = 0;
    for (int f = 0; f < 30; f++) begin
      wait_idle();
      nit = $urandom_range(0, 3);
      strobe_log.delete();
      start_frame(TITW'(nit));
      run_until_done(3000, 1'b1);
      repeat (2) @(negedge clk);
      check("frame_strobes", 32'(strobe_log.size()),
            32'((nit == 0) ? 0 : TN + 3 + 5 * (nit - 1)));
      $display("frame %0d niter=%0d strobes=%0d", f, nit, strobe_log.size());
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
